// File: rtl/stalling_unit_pkg.sv
// ----------------------------------------------------------------------------
// stalling_unit_pkg
//   Shared definitions for the pipeline stalling unit:
//     - md_state_e         : occupancy FSM encoding (IDLE=0, BUSY=1)
//     - REG_AW             : register-address width (5 bits, 32 GPRs)
//     - MD_LATENCY_DEFAULT : default multiply/divide occupancy in cycles
//     - MD_CNT_W           : width of the occupancy down-counter (1..15 fits)
// ----------------------------------------------------------------------------
package stalling_unit_pkg;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam int unsigned REG_AW             = 5;
  localparam int unsigned MD_LATENCY_DEFAULT = 4;
  localparam int unsigned MD_CNT_W           = 4;

endpackage : stalling_unit_pkg

// File: rtl/stalling_unit_mdbusytracker.sv
// ----------------------------------------------------------------------------
// mdbusytracker
//   Tracks how long the HI/LO multiply/divide unit stays occupied.
//   Two-state FSM (IDLE/BUSY) plus a 4-bit down-counter.
//
// Ports
//   clk      in   clock, rising edge
//   rst_n    in   synchronous active-low reset
//   start_i  in   accept strobe for a new mult/div (already qualified by the
//                 caller with "not stalled"); only honoured in IDLE
//   state_o  out  current FSM state (MD_BUSY means HI/LO is in flight)
//
// Handshake: start_i is a single-cycle acceptance strobe. In IDLE a high
// start_i is consumed on that clock edge; in BUSY it is ignored, and the
// caller is expected to stall the requester until the FSM is back in IDLE.
// ----------------------------------------------------------------------------
module mdbusytracker
  import stalling_unit_pkg::*;
#(
  parameter int unsigned MD_LATENCY = MD_LATENCY_DEFAULT
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      start_i,
  output md_state_e state_o
);

  localparam logic [MD_CNT_W-1:0] LAT_LOAD = MD_CNT_W'(MD_LATENCY);
  localparam logic [MD_CNT_W-1:0] CNT_ONE  = MD_CNT_W'(1);

  md_state_e           state_q, state_d;
  logic [MD_CNT_W-1:0] cnt_q,   cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MD_IDLE: begin
        if (start_i) begin
          state_d = MD_BUSY;
          cnt_d   = LAT_LOAD;
        end
      end
      MD_BUSY: begin
        // The counter holds the number of BUSY cycles still to run,
        // including the current one; a value of 1 is the last BUSY cycle.
        if (cnt_q == CNT_ONE) begin
          state_d = MD_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign state_o = state_q;

endmodule : mdbusytracker

// File: rtl/stalling_unit.sv
// ----------------------------------------------------------------------------
// stalling_unit
//   Hazard detection for a 5-stage MIPS pipeline. Stalls fetch/decode and
//   bubbles execute on a load-use hazard, or when a decode instruction
//   touches HI/LO (or starts another mult/div) while one is still in flight.
//
// Parameters
//   MD_LATENCY  cycles a mult/div occupies HI/LO (1..15)
//   CNT_W       width of the stalled-cycle performance counter
//
// Ports
//   clk, rst_n            clock / synchronous active-low reset
//   RsD, RtD              decode-stage source registers
//   UsesRsD, UsesRtD      decode instruction actually reads rs / rt
//   RtE                   execute-stage destination register
//   MemtoRegE             execute-stage instruction is a load
//   MDStartD              decode instruction is mult/multu/div/divu
//   MDUseD                decode instruction is mfhi/mflo/mthi/mtlo
//   PCEn                  PC enable (0 = stall)
//   EnD                   IF/ID enable (0 = stall)
//   FlushE                turn ID/EX into a bubble
//   MDBusy                mult/div in flight
//   StallCnt              saturating count of stalled cycles since reset
// ----------------------------------------------------------------------------
module stalling_unit
  import stalling_unit_pkg::*;
#(
  parameter int unsigned MD_LATENCY = MD_LATENCY_DEFAULT,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic              UsesRsD,
  input  logic              UsesRtD,
  input  logic [REG_AW-1:0] RtE,
  input  logic              MemtoRegE,
  input  logic              MDStartD,
  input  logic              MDUseD,
  output logic              PCEn,
  output logic              EnD,
  output logic              FlushE,
  output logic              MDBusy,
  output logic [CNT_W-1:0]  StallCnt
);

  logic             load_use;
  logic             md_haz;
  logic             stall;
  logic             md_start;
  md_state_e        md_state;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // $zero as a load destination never creates a dependency.
  assign load_use = MemtoRegE && (RtE != '0) &&
                    ((UsesRsD && (RsD == RtE)) || (UsesRtD && (RtD == RtE)));

  assign md_haz = MDBusy && (MDUseD || MDStartD);
  assign stall  = load_use || md_haz;

  assign PCEn   = ~stall;
  assign EnD    = ~stall;
  assign FlushE = stall;

  // A start that is itself being stalled (e.g. by a coincident load-use)
  // must not launch the tracker; it is retried once the stall clears.
  assign md_start = MDStartD && !stall;

  mdbusytracker #(
    .MD_LATENCY (MD_LATENCY)
  ) u_mdbusytracker (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (md_start),
    .state_o (md_state)
  );

  assign MDBusy = (md_state == MD_BUSY);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;

endmodule : stalling_unit
